// File: rtl/bus_edge_stretcher.sv
// Multi-channel edge-triggered pulse stretcher for 6809 bus strobes: sync, edge detect,
// programmable hold with retrigger, optional post-pulse guard lockout and sticky overrun.
//
// state | meaning
// IDLE  | waiting for a qualifying edge, o_active low
// HOLD  | stretched pulse running, counter counts down to zero
// GUARD | lockout after a pulse, edges dropped and flagged as overrun
module bus_edge_stretcher #(
    parameter int   CHANNELS    = 4,
    parameter int   CNT_W       = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   GUARD_CYC   = 0,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS-1:0]       i_sig,
    input  logic [2*CHANNELS-1:0]     i_edge_sel,
    input  logic [CNT_W*CHANNELS-1:0] i_hold_cnt,
    input  logic [CHANNELS-1:0]       i_retrig,
    input  logic [CHANNELS-1:0]       i_clr_ovr,
    output logic [CHANNELS-1:0]       o_active,
    output logic [CHANNELS-1:0]       o_active_n,
    output logic [CHANNELS-1:0]       o_overrun,
    output logic                      o_busy
);

    localparam int GCNT_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [GCNT_W-1:0] GUARD_LOAD = GCNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    logic [CHANNELS-1:0] busy_d;
    logic                busy_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   rise_q;
        logic                   fall_q;
        state_e                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic [GCNT_W-1:0]      gcnt_q, gcnt_d;
        logic                   act_q, act_d;
        logic                   act_n_q;
        logic                   ovr_q, ovr_d;
        logic [1:0]             sel;
        logic [CNT_W-1:0]       hold;
        logic                   qual;

        assign sel  = i_edge_sel[2*c +: 2];
        assign hold = i_hold_cnt[CNT_W*c +: CNT_W];
        // Edge pulses are registered, so qualification sees the select value current at the FSM edge.
        assign qual = (sel[0] & rise_q) | (sel[1] & fall_q);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            gcnt_d  = gcnt_q;
            act_d   = act_q;
            ovr_d   = ovr_q & ~i_clr_ovr[c];
            unique case (state_q)
                ST_IDLE: begin
                    if (qual) begin
                        state_d = ST_HOLD;
                        cnt_d   = hold;
                        act_d   = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (sel == 2'b00) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        act_d   = 1'b0;
                    end else if (qual && i_retrig[c]) begin
                        cnt_d = hold;
                    end else begin
                        if (qual) begin
                            ovr_d = 1'b1;
                        end
                        if (cnt_q == '0) begin
                            act_d = 1'b0;
                            if (GUARD_CYC > 0) begin
                                state_d = ST_GUARD;
                                gcnt_d  = GUARD_LOAD;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                ST_GUARD: begin
                    act_d = 1'b0;
                    if (sel == 2'b00) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        gcnt_d  = '0;
                    end else begin
                        if (qual) begin
                            ovr_d = 1'b1;
                        end
                        if (gcnt_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            gcnt_d = gcnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    gcnt_d  = '0;
                    act_d   = 1'b0;
                end
            endcase
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
                prev_q  <= IDLE_LEVEL;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                gcnt_q  <= '0;
                act_q   <= 1'b0;
                act_n_q <= 1'b1;
                ovr_q   <= 1'b0;
            end else begin
                sync_q[0] <= i_sig[c];
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
                prev_q  <= sync_q[SYNC_STAGES-1];
                rise_q  <= sync_q[SYNC_STAGES-1] & ~prev_q;
                fall_q  <= ~sync_q[SYNC_STAGES-1] & prev_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                gcnt_q  <= gcnt_d;
                act_q   <= act_d;
                act_n_q <= ~act_d;
                ovr_q   <= ovr_d;
            end
        end

        assign busy_d[c]     = (state_d != ST_IDLE);
        assign o_active[c]   = act_q;
        assign o_active_n[c] = act_n_q;
        assign o_overrun[c]  = ovr_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |busy_d;
        end
    end

    assign o_busy = busy_q;

endmodule

// File: tb/tb_bus_edge_stretcher.sv
// Scoreboard bench for bus_edge_stretcher: a 4-channel no-guard instance and a
// 1-channel instance with a 3-cycle guard, checked every cycle against spec timing.
module tb_bus_edge_stretcher;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sig;
    logic [7:0]  sel;
    logic [15:0] hold;
    logic [3:0]  retrig;
    logic [3:0]  clr;
    logic [3:0]  act;
    logic [3:0]  act_n;
    logic [3:0]  ovr;
    logic        busy;

    logic        g_sig;
    logic [1:0]  g_sel;
    logic [3:0]  g_hold;
    logic        g_retrig;
    logic        g_clr;
    logic        g_act;
    logic        g_act_n;
    logic        g_ovr;
    logic        g_busy;

    int vectors;
    int miscompares;

    typedef struct {
        logic [3:0] act;
        logic [3:0] ovr;
        logic       busy;
        logic       gact;
        logic       govr;
        logic       gbusy;
    } exp_t;

    exp_t sb[$];

    bus_edge_stretcher #(
        .CHANNELS(4), .CNT_W(4), .SYNC_STAGES(2), .GUARD_CYC(0), .IDLE_LEVEL(1'b1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sig(sig), .i_edge_sel(sel), .i_hold_cnt(hold),
        .i_retrig(retrig), .i_clr_ovr(clr), .o_active(act), .o_active_n(act_n),
        .o_overrun(ovr), .o_busy(busy)
    );

    bus_edge_stretcher #(
        .CHANNELS(1), .CNT_W(4), .SYNC_STAGES(2), .GUARD_CYC(3), .IDLE_LEVEL(1'b1)
    ) dut_g (
        .i_clk(clk), .i_rst_n(rst_n), .i_sig(g_sig), .i_edge_sel(g_sel), .i_hold_cnt(g_hold),
        .i_retrig(g_retrig), .i_clr_ovr(g_clr), .o_active(g_act), .o_active_n(g_act_n),
        .o_overrun(g_ovr), .o_busy(g_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t quiet();
        exp_t e;
        e.act   = '0;
        e.ovr   = '0;
        e.busy  = 1'b0;
        e.gact  = 1'b0;
        e.govr  = 1'b0;
        e.gbusy = 1'b0;
        return e;
    endfunction

    // Iteration j: stimulus applied 1 ns after a rising edge, outputs sampled at the
    // following falling edge. A pin change at iteration d acts on the FSM at iteration d+4.
    task automatic test_reset();
        exp_t e;
        logic [15:0] obs, want;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            rst_n = (j >= 3);
            e = quiet();
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            obs  = {act, act_n, ovr, busy, g_act, g_act_n, g_ovr, g_busy};
            want = {e.act, ~e.act, e.ovr, e.busy, e.gact, ~e.gact, e.govr, e.gbusy};
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL reset j=%0d got=%h want=%h", j, obs, want);
            end
        end
    endtask

    task automatic test_basic_fall();
        exp_t e;
        logic [15:0] obs, want;
        hold[3:0] = 4'd2;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            if (j == 0) sig[0] = 1'b0;
            if (j == 9) sig[0] = 1'b1;
            e = quiet();
            e.act[0] = (j >= 4 && j <= 6);
            e.busy   = e.act[0];
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            obs  = {act, act_n, ovr, busy, g_act, g_act_n, g_ovr, g_busy};
            want = {e.act, ~e.act, e.ovr, e.busy, e.gact, ~e.gact, e.govr, e.gbusy};
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL basic_fall j=%0d got=%h want=%h", j, obs, want);
            end
        end
    endtask

    task automatic test_both_edges();
        exp_t e;
        logic [15:0] obs, want;
        sel[3:2]  = 2'b11;
        hold[7:4] = 4'd0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #1;
            if (j % 4 == 0 && j <= 12) sig[1] = ~sig[1];
            e = quiet();
            e.act[1] = (j == 4 || j == 8 || j == 12 || j == 16);
            e.busy   = e.act[1];
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            obs  = {act, act_n, ovr, busy, g_act, g_act_n, g_ovr, g_busy};
            want = {e.act, ~e.act, e.ovr, e.busy, e.gact, ~e.gact, e.govr, e.gbusy};
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL both_edges j=%0d got=%h want=%h", j, obs, want);
            end
        end
        sel[3:2] = 2'b10;
    endtask

    // Run 0 retriggers, run 1 drops the edge and clears later, run 2 holds clear during the set.
    task automatic test_retrig();
        exp_t e;
        logic [15:0] obs, want;
        hold[11:8] = 4'd5;
        for (int r = 0; r < 3; r++) begin
            retrig[2] = (r == 0);
            for (int j = 0; j < 22; j++) begin
                @(posedge clk); #1;
                if (j == 0 || j == 3) sig[2] = 1'b0;
                if (j == 1 || j == 16) sig[2] = 1'b1;
                clr[2] = (r == 1) ? (j == 14) : ((r == 2) ? (j <= 15) : 1'b0);
                e = quiet();
                e.act[2] = (r == 0) ? (j >= 4 && j <= 12) : (j >= 4 && j <= 9);
                e.ovr[2] = (r == 1) ? (j >= 7 && j <= 14) : ((r == 2) ? (j == 7) : 1'b0);
                e.busy   = e.act[2];
                sb.push_back(e);
                @(negedge clk);
                e = sb.pop_front();
                obs  = {act, act_n, ovr, busy, g_act, g_act_n, g_ovr, g_busy};
                want = {e.act, ~e.act, e.ovr, e.busy, e.gact, ~e.gact, e.govr, e.gbusy};
                vectors++;
                if (obs !== want) begin
                    miscompares++;
                    $display("FAIL retrig r=%0d j=%0d got=%h want=%h", r, j, obs, want);
                end
            end
        end
        retrig[2] = 1'b0;
        clr[2]    = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [15:0] obs, want;
        hold[3:0] = 4'd1;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk); #1;
            if (j == 0 || j == 3) sig[0] = 1'b0;
            if (j == 1 || j == 12) sig[0] = 1'b1;
            e = quiet();
            e.act[0] = (j == 4 || j == 5 || j == 7 || j == 8);
            e.busy   = e.act[0];
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            obs  = {act, act_n, ovr, busy, g_act, g_act_n, g_ovr, g_busy};
            want = {e.act, ~e.act, e.ovr, e.busy, e.gact, ~e.gact, e.govr, e.gbusy};
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL back_to_back j=%0d got=%h want=%h", j, obs, want);
            end
        end
    endtask

    task automatic test_hold_change();
        exp_t e;
        logic [15:0] obs, want;
        hold[3:0] = 4'd3;
        for (int j = 0; j < 14; j++) begin
            @(posedge clk); #1;
            if (j == 0) sig[0] = 1'b0;
            if (j == 5) hold[3:0] = 4'd9;
            if (j == 10) sig[0] = 1'b1;
            e = quiet();
            e.act[0] = (j >= 4 && j <= 7);
            e.busy   = e.act[0];
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            obs  = {act, act_n, ovr, busy, g_act, g_act_n, g_ovr, g_busy};
            want = {e.act, ~e.act, e.ovr, e.busy, e.gact, ~e.gact, e.govr, e.gbusy};
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL hold_change j=%0d got=%h want=%h", j, obs, want);
            end
        end
        hold[3:0] = 4'd2;
    endtask

    task automatic test_sel_off();
        exp_t e;
        logic [15:0] obs, want;
        hold[3:0] = 4'd7;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk); #1;
            if (j == 0) sig[0] = 1'b0;
            if (j == 6) sel[1:0] = 2'b00;
            if (j == 8) sig[0] = 1'b1;
            if (j == 10) sel[1:0] = 2'b10;
            e = quiet();
            e.act[0] = (j >= 4 && j <= 6);
            e.busy   = e.act[0];
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            obs  = {act, act_n, ovr, busy, g_act, g_act_n, g_ovr, g_busy};
            want = {e.act, ~e.act, e.ovr, e.busy, e.gact, ~e.gact, e.govr, e.gbusy};
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL sel_off j=%0d got=%h want=%h", j, obs, want);
            end
        end
        hold[3:0] = 4'd2;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [15:0] obs, want;
        hold[15:12] = 4'd7;
        for (int j = 0; j < 18; j++) begin
            @(posedge clk); #1;
            if (j == 0) sig[3] = 1'b0;
            if (j == 5) begin
                rst_n  = 1'b0;
                sig[3] = 1'b1;
            end
            if (j == 7) rst_n = 1'b1;
            e = quiet();
            e.act[3] = (j == 4 || j == 5);
            e.busy   = e.act[3];
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            obs  = {act, act_n, ovr, busy, g_act, g_act_n, g_ovr, g_busy};
            want = {e.act, ~e.act, e.ovr, e.busy, e.gact, ~e.gact, e.govr, e.gbusy};
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL reset_mid j=%0d got=%h want=%h", j, obs, want);
            end
        end
    endtask

    // Guard build, H=2: pulse 3 cycles then 3 guard cycles.
    // Run 0: edge in guard dropped, edge after guard accepted. Run 1: edge on final guard cycle dropped.
    task automatic test_guard();
        exp_t e;
        logic [15:0] obs, want;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 24; j++) begin
                @(posedge clk); #1;
                if (r == 0) begin
                    if (j == 0 || j == 4 || j == 7) g_sig = 1'b0;
                    if (j == 1 || j == 5 || j == 20) g_sig = 1'b1;
                end else begin
                    g_clr = (j == 0);
                    if (j == 2 || j == 8) g_sig = 1'b0;
                    if (j == 3 || j == 20) g_sig = 1'b1;
                end
                e = quiet();
                if (r == 0) begin
                    e.gact  = (j >= 4 && j <= 6) || (j >= 11 && j <= 13);
                    e.gbusy = (j >= 4 && j <= 9) || (j >= 11 && j <= 16);
                    e.govr  = (j >= 8);
                end else begin
                    e.gact  = (j >= 6 && j <= 8);
                    e.gbusy = (j >= 6 && j <= 11);
                    e.govr  = (j == 0) || (j >= 12);
                end
                sb.push_back(e);
                @(negedge clk);
                e = sb.pop_front();
                obs  = {act, act_n, ovr, busy, g_act, g_act_n, g_ovr, g_busy};
                want = {e.act, ~e.act, e.ovr, e.busy, e.gact, ~e.gact, e.govr, e.gbusy};
                vectors++;
                if (obs !== want) begin
                    miscompares++;
                    $display("FAIL guard r=%0d j=%0d got=%h want=%h", r, j, obs, want);
                end
            end
        end
        g_clr = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        sig      = 4'hF;
        sel      = 8'b10101010;
        hold     = 16'h2222;
        retrig   = 4'h0;
        clr      = 4'h0;
        g_sig    = 1'b1;
        g_sel    = 2'b10;
        g_hold   = 4'd2;
        g_retrig = 1'b0;
        g_clr    = 1'b0;

        test_reset();
        test_basic_fall();
        test_both_edges();
        test_retrig();
        test_back_to_back();
        test_hold_change();
        test_sel_off();
        test_reset_mid();
        test_guard();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
